chunk_seq_multiplier: RTL

Parametrised, multi-cycle integer multiplier that builds a full `2*WIDTH`-bit product from `CHUNK x CHUNK` partial products, one per clock, accumulated with the correct shift. It generalises the fixed 16-bit four-quadrant multiplier to any `WIDTH` that is a multiple of `CHUNK`, and adds signed/unsigned mode and valid/ready handshakes. It sits in the FP multiplier datapath as the mantissa multiplier and can also be used stand-alone.

---
 rtl/chunk_seq_multiplier_pkg.sv | 26 ++
 rtl/chunk_seq_multiplier_chunk_mul.sv | 24 ++
 rtl/chunk_seq_multiplier.sv | 132 +++++++++++++
 3 files changed

// File: rtl/chunk_seq_multiplier_pkg.sv
// ============================================================================
// Module      : chunk_seq_multiplier_pkg
// Description : Shared state encoding, default chunk width and index-width
//               helper for the chunked sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chunk_seq_multiplier_pkg;

  localparam int DEFAULT_CHUNK = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for an index running 0..n-1, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chunk_seq_multiplier_chunk_mul.sv
// ============================================================================
// Module      : chunk_mul
// Description : Combinational CHUNK x CHUNK -> 2*CHUNK unsigned multiplier,
//               time-shared by the sequential multiplier top.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_mul
  import chunk_seq_multiplier_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0]   x,
  input  logic [CHUNK-1:0]   y,
  output logic [2*CHUNK-1:0] p
);

  // Operands zero-extended to the product width so no bits are lost
  assign p = {{CHUNK{1'b0}}, x} * {{CHUNK{1'b0}}, y};

endmodule

`default_nettype wire

// File: rtl/chunk_seq_multiplier.sv
// ============================================================================
// Module      : chunk_seq_multiplier
// Description : Multi-cycle WIDTH x WIDTH multiplier producing an exact
//               2*WIDTH product from one CHUNK x CHUNK partial product per
//               clock, with signed/unsigned mode and valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_seq_multiplier
  import chunk_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = idx_width(N);
  localparam int PW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_param_check
      $error("chunk_seq_multiplier: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t            state;
  logic [IW-1:0]     i_idx;
  logic [IW-1:0]     j_idx;
  logic [WIDTH-1:0]  ma;
  logic [WIDTH-1:0]  mb;
  logic              neg;
  logic [PW-1:0]     acc;

  logic [CHUNK-1:0]   slice_a;
  logic [CHUNK-1:0]   slice_b;
  logic [2*CHUNK-1:0] pp;
  logic [PW-1:0]      acc_next;
  logic               last_step;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Magnitudes: two's-complement negate only for negative signed operands;
  // the most-negative value maps onto 2^(WIDTH-1), which still fits unsigned
  assign mag_a = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Select chunk i of |a| and chunk j of |b| (chunk 0 holds the LSBs)
  assign slice_a = CHUNK'(ma >> (CHUNK * int'(i_idx)));
  assign slice_b = CHUNK'(mb >> (CHUNK * int'(j_idx)));

  chunk_mul #(
    .CHUNK (CHUNK)
  ) u_chunk_mul (
    .x (slice_a),
    .y (slice_b),
    .p (pp)
  );

  // Partial product weighted by its chunk position before accumulation
  assign acc_next  = acc + (PW'(pp) << (CHUNK * (int'(i_idx) + int'(j_idx))));
  assign last_step = (i_idx == LAST_IDX) && (j_idx == LAST_IDX);

  // Handshake outputs decode the state register only
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // Sequencer: accept, step through all N*N chunk pairs, then hold result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      i_idx   <= '0;
      j_idx   <= '0;
      ma      <= '0;
      mb      <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            ma    <= mag_a;
            mb    <= mag_b;
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          acc <= acc_next;
          if (last_step) begin
            product <= neg ? (~acc_next + 1'b1) : acc_next;
            i_idx   <= '0;
            j_idx   <= '0;
            state   <= ST_DONE;
          end else if (j_idx == LAST_IDX) begin
            j_idx <= '0;
            i_idx <= i_idx + 1'b1;
          end else begin
            j_idx <= j_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
